// File: rtl/baud_pkg.sv
// Shared widths and 50 MHz divisor presets for the fractional UART baud generator.
// Presets assume x24 oversampling: rx period = div + 1 + frac/16 clks.
package baud_pkg;

  localparam int BAUD_DIV_W   = 16;
  localparam int BAUD_FRAC_W  = 4;
  localparam int BAUD_OSR_W   = 5;

  localparam int BAUD_DEF_DIV  = 26;
  localparam int BAUD_DEF_FRAC = 0;
  localparam int BAUD_DEF_OSR  = 23;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  div;
    logic [BAUD_FRAC_W-1:0] frac;
    logic [BAUD_OSR_W-1:0]  osr;
  } baud_cfg_t;

  // 50e6 / (baud * 24) expressed as div + 1 + frac/16
  localparam baud_cfg_t CFG_9600   = '{div: 16'd216, frac: 4'd0, osr: 5'd23};
  localparam baud_cfg_t CFG_76800  = '{div: 16'd26,  frac: 4'd2, osr: 5'd23};
  localparam baud_cfg_t CFG_115200 = '{div: 16'd17,  frac: 4'd1, osr: 5'd23};
  localparam baud_cfg_t CFG_230400 = '{div: 16'd8,   frac: 4'd1, osr: 5'd23};

endpackage

// File: rtl/baud_frac_div.sv
// Fractional-N divider producing the oversample strobe; the fraction accumulator
// stretches one period by a clk whenever it overflows.
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int DIV_W  = BAUD_DIV_W,
  parameter int FRAC_W = BAUD_FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_phase_rst,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_rx_clk_en
);

  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [DIV_W-1:0]  w_lim;
  logic [FRAC_W:0]   w_sum;
  logic              w_tick;

  assign w_lim       = i_div + {{(DIV_W-1){1'b0}}, r_carry};
  assign w_sum       = {1'b0, r_acc} + {1'b0, i_frac};
  assign w_tick      = ~i_rst & i_en & ~i_phase_rst & (r_cnt == w_lim);
  assign o_rx_clk_en = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_phase_rst || !i_en) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_acc   <= w_sum[FRAC_W-1:0];
      r_carry <= w_sum[FRAC_W];
    end else begin
      r_cnt   <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// UART baud generator: oversample and bit strobes with shadowed configuration that
// only takes effect on a bit boundary (or immediately while disabled).
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W    = BAUD_DIV_W,
  parameter int FRAC_W   = BAUD_FRAC_W,
  parameter int OSR_W    = BAUD_OSR_W,
  parameter int DEF_DIV  = BAUD_DEF_DIV,
  parameter int DEF_FRAC = BAUD_DEF_FRAC,
  parameter int DEF_OSR  = BAUD_DEF_OSR
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_cfg_div,
  input  logic [FRAC_W-1:0] i_cfg_frac,
  input  logic [OSR_W-1:0]  i_cfg_osr,
  input  logic              i_cfg_load,
  output logic              o_cfg_ack,
  input  logic              i_phase_rst,
  output logic              o_rx_clk_en,
  output logic              o_tx_clk_en
);

  logic [DIV_W-1:0]  r_div_q;
  logic [FRAC_W-1:0] r_frac_q;
  logic [OSR_W-1:0]  r_osr_q;
  logic [DIV_W-1:0]  r_shd_div;
  logic [FRAC_W-1:0] r_shd_frac;
  logic [OSR_W-1:0]  r_shd_osr;
  logic              r_pend;
  logic [OSR_W-1:0]  r_tx_cnt;
  logic              w_rx;
  logic              w_tx;
  logic              w_apply;

  baud_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_phase_rst (i_phase_rst),
    .i_div       (r_div_q),
    .i_frac      (r_frac_q),
    .o_rx_clk_en (w_rx)
  );

  assign w_tx    = w_rx & (r_tx_cnt == r_osr_q);
  // Switching only on a bit boundary or while idle keeps every strobe glitch-free.
  assign w_apply = ~i_rst & r_pend & (w_tx | ~i_en);

  assign o_rx_clk_en = w_rx;
  assign o_tx_clk_en = w_tx;
  assign o_cfg_ack   = w_apply;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_phase_rst || !i_en) begin
      r_tx_cnt <= '0;
    end else if (w_rx) begin
      r_tx_cnt <= (r_tx_cnt == r_osr_q) ? '0 : r_tx_cnt + OSR_W'(1);
    end else begin
      r_tx_cnt <= r_tx_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_q    <= DIV_W'(DEF_DIV);
      r_frac_q   <= FRAC_W'(DEF_FRAC);
      r_osr_q    <= OSR_W'(DEF_OSR);
      r_shd_div  <= DIV_W'(DEF_DIV);
      r_shd_frac <= FRAC_W'(DEF_FRAC);
      r_shd_osr  <= OSR_W'(DEF_OSR);
      r_pend     <= 1'b0;
    end else begin
      if (i_cfg_load) begin
        r_shd_div  <= i_cfg_div;
        r_shd_frac <= i_cfg_frac;
        r_shd_osr  <= i_cfg_osr;
      end
      if (w_apply) begin
        // A load landing on the apply cycle wins over the older shadow contents.
        r_div_q  <= i_cfg_load ? i_cfg_div  : r_shd_div;
        r_frac_q <= i_cfg_load ? i_cfg_frac : r_shd_frac;
        r_osr_q  <= i_cfg_load ? i_cfg_osr  : r_shd_osr;
        r_pend   <= 1'b0;
      end else if (i_cfg_load) begin
        r_pend   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional-N baud-rate generator for the UART, successor to the fixed 8-bit/fixed-oversample generator. Produces an oversample strobe (`rx_clk_en`) for the receiver and a bit strobe (`tx_clk_en`) for the transmitter from one system clock. It adds a fractional divisor, a runtime-selectable oversample ratio, glitch-free reconfiguration on bit boundaries, and a phase-resync input. It sits between the register block and the UART tx/rx cores.

## Interface
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 4: fractional divisor width (resolution 1/2^FRAC_W clk).
- `OSR_W`, 5: oversample-count width.
- `DEF_DIV`, 26: reset value of active integer divisor.
- `DEF_FRAC`, 0: reset value of active fractional divisor.
- `DEF_OSR`, 23: reset value of active oversample count (ratio = value+1).

- `clk` in 1: system clock; sole clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: generator enable.
- `cfg_div` in DIV_W: new integer divisor.
- `cfg_frac` in FRAC_W: new fractional divisor.
- `cfg_osr` in OSR_W: new oversample count.
- `cfg_load` in 1: one-cycle pulse; capture `cfg_*` into shadow.
- `cfg_ack` out 1: one-cycle pulse when shadow becomes active.
- `phase_rst` in 1: resync pulse; restarts divider and bit phase.
- `rx_clk_en` out 1: oversample strobe, one cycle wide.
- `tx_clk_en` out 1: bit strobe, one cycle wide, always coincident with an `rx_clk_en`.

## Operation
- Active regs `div_q`, `frac_q`, `osr_q`; reset to DEF_*. Shadow regs plus `pend` flag; `pend` resets to 0.
- Divider: `cnt` (DIV_W) counts 0..`lim`, `lim = div_q + carry_q`. `rx_clk_en = en & ~phase_rst & (cnt == lim)`; `cnt` wraps to 0 on that cycle.
- Fraction: on each `rx_clk_en`, `{carry, acc} = acc + frac_q` (FRAC_W+1-bit sum); `carry_q` latches carry, stretching the next period by one clk. Mean rx period = div_q + 1 + frac_q/2^FRAC_W clks.
- Bit counter `tx_cnt` (OSR_W) advances on `rx_clk_en`, wraps at `osr_q`. `tx_clk_en = rx_clk_en & (tx_cnt == osr_q)`.
- Reconfig: `cfg_load` writes shadow, sets `pend`. Apply when `pend & (tx_clk_en | ~en)`: active ← shadow, `pend` cleared, `cfg_ack` = 1 that cycle. Apply affects the period starting next cycle; counters are not cleared.
- `cfg_load` while `pend`: shadow overwritten, one ack only. `cfg_load` on an apply cycle: the incoming `cfg_*` values are applied directly (latest wins); `pend` ends 0.
- `en` = 0: `cnt`, `tx_cnt`, `acc`, `carry_q` held at 0; strobes 0.
- `phase_rst`: highest priority after `rst`; clears `cnt`, `tx_cnt`, `acc`, `carry_q`; strobes 0 that cycle; does not touch config or `pend`.
- `div_q` = 0, `frac_q` = 0: `rx_clk_en` every enabled cycle (legal).

## Timing
- Reset: all outputs 0; counters 0; active = DEF_*.
- After `rst` drops with `en` = 1: first `rx_clk_en` in the (div_q+1)th cycle (cycle index div_q, counting from 0).
- Strobes are combinational from registered state and `en`/`phase_rst`; no extra latency.
- `cfg_ack` is registered-state derived, same cycle as the apply.
- `rst` mid-operation discards pending config; `cfg_ack` not issued.

## Structure
- Package `baud_pkg`: default-divisor constants for common baud rates at 50 MHz, plus widths exported as localparams.
- One sub-module `baud_frac_div` (cnt, acc, carry, `rx_clk_en`); top holds the `tx_cnt`, config shadow/apply logic.

## Test plan
- Reset defaults, `en` = 1: `rx_clk_en` every 27 clks, `tx_clk_en` every 648 clks; first `rx_clk_en` at cycle 26.
- `div` = 3, `frac` = 8 (FRAC_W = 4): rx periods alternate 4,5; 32 ticks span 144 clks.
- `cfg_load` (`div` = 9, `osr` = 7) mid-bit: old period continues until next `tx_clk_en`; `cfg_ack` coincides with it; next bit = 80 clks.
- Two `cfg_load`s before boundary, second on the apply cycle: one `cfg_ack`, second values active.
- `phase_rst` at `tx_cnt` = 5: strobes 0 that cycle; next `tx_clk_en` exactly (osr+1)·(div+1) clks later (frac = 0).
- `en` = 0 with `pend` = 1: ack next cycle; re-enable gives first rx tick after new div+1 clks.
